mat_xpose_dma_ctrl: RTL and testbench

//  Matrix-transpose DMA sequencer and data-memory arbiter between the openMSP430 dmem port and dmem_0.
//  - Copies a rows x cols matrix of 16-bit words from SRC (row-major) to DST as its transpose
//    (cols x rows, row-major).
//  - Shares the single-port data RAM with the CPU. The CPU always has priority; the engine uses idle cycles.

---
 rtl/mat_xpose_dma_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mat_xpose_dma_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_xpose_dma_ctrl.sv
// mat_xpose_dma_ctrl
// Matrix-transpose DMA sequencer and arbiter for the single-port data RAM.
// It copies a rows x cols matrix of 16-bit words from cfg_src (row-major) to
// cfg_dst as its transpose (cols x rows, row-major). The CPU always has
// priority on the RAM, and the engine only uses cycles in which the CPU is idle.
//
// Build option: define MAT_XPOSE_IRQ_EN to get a sticky completion interrupt.
// When it is undefined, irq is tied low and irq_ack is ignored.
//
// Ports
//   mclk, reset_n               clock, asynchronous active-low reset
//   cfg_src/dst/rows/cols       transfer setup, latched when start is accepted
//   start                       one-cycle start request (ignored while busy)
//   busy, done, irq, irq_ack    status, completion pulse, interrupt and its clear
//   cpu_addr/cen/wen/din/dout   CPU data-memory port
//   mem_addr/cen/wen/din/dout   RAM port (read data valid one cycle after the access)
//
// state | meaning
// IDLE  | no transfer; waits for start
// RD    | requests a read of src_ptr; holds while the CPU owns the RAM
// CAP   | no request; latches the read word into data_q
// WR    | requests a write of data_q to dst_ptr; holds while the CPU owns the RAM
module mat_xpose_dma_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DIM_W  = 4
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [DIM_W-1:0]  cfg_rows,
  input  logic [DIM_W-1:0]  cfg_cols,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              irq,
  input  logic              irq_ack,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_cen,
  input  logic [1:0]        cpu_wen,
  input  logic [15:0]       cpu_din,
  output logic [15:0]       cpu_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cen,
  output logic [1:0]        mem_wen,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_WR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr, dst_ptr, dst_base;
  logic [DIM_W-1:0]  rows_q, cols_q, r_q, c_q;
  logic [15:0]       data_q;
  logic              done_q;

  logic              eng_cen;
  logic [1:0]        eng_wen;
  logic [ADDR_W-1:0] eng_addr;

  logic accept, zero_dim, wr_grant, last_col, last_elem, done_set;

  assign accept    = (state_q == S_IDLE) && start;
  assign zero_dim  = (cfg_rows == '0) || (cfg_cols == '0);
  // The engine request is granted whenever the CPU is not using the RAM.
  assign wr_grant  = (state_q == S_WR) && cpu_cen;
  assign last_col  = (c_q == cols_q - DIM_W'(1));
  assign last_elem = last_col && (r_q == rows_q - DIM_W'(1));
  assign done_set  = (accept && zero_dim) || (wr_grant && last_elem);

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    eng_cen  = 1'b1;
    eng_wen  = 2'b11;
    eng_addr = '0;
    case (state_q)
      S_IDLE: if (accept && !zero_dim) state_d = S_RD;
      S_RD: begin
        eng_cen  = 1'b0;
        eng_addr = src_ptr;
        if (cpu_cen) state_d = S_CAP;
      end
      S_CAP: state_d = S_WR;
      S_WR: begin
        eng_cen  = 1'b0;
        eng_wen  = 2'b00;
        eng_addr = dst_ptr;
        if (cpu_cen) state_d = last_elem ? S_IDLE : S_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      src_ptr  <= '0;
      dst_ptr  <= '0;
      dst_base <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      r_q      <= '0;
      c_q      <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_set;
      if (accept) begin
        src_ptr  <= cfg_src;
        dst_ptr  <= cfg_dst;
        dst_base <= cfg_dst;
        rows_q   <= cfg_rows;
        cols_q   <= cfg_cols;
        r_q      <= '0;
        c_q      <= '0;
      end
      // The read word is on mem_dout during CAP whatever the CPU does in this
      // cycle, because a CPU access here only changes mem_dout on the next edge.
      if (state_q == S_CAP) data_q <= mem_dout;
      if (wr_grant) begin
        src_ptr <= src_ptr + ADDR_W'(1);
        if (!last_col) begin
          c_q     <= c_q + DIM_W'(1);
          dst_ptr <= dst_ptr + ADDR_W'(rows_q);
        end else begin
          // The next source row becomes the next destination column.
          c_q     <= '0;
          r_q     <= r_q + DIM_W'(1);
          dst_ptr <= dst_base + ADDR_W'(r_q) + ADDR_W'(1);
        end
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign cpu_dout = mem_dout;

  assign mem_addr = cpu_cen ? eng_addr : cpu_addr;
  assign mem_cen  = cpu_cen ? eng_cen  : 1'b0;
  assign mem_wen  = cpu_cen ? eng_wen  : cpu_wen;
  assign mem_din  = cpu_cen ? data_q   : cpu_din;

`ifdef MAT_XPOSE_IRQ_EN
  logic irq_q;
  // A set on done takes priority over an acknowledge in the same cycle.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n)                irq_q <= 1'b0;
    else if (done_set)           irq_q <= 1'b1;
    else if (irq_ack && !done_q) irq_q <= 1'b0;
  end
  assign irq = irq_q;
`else
  logic irq_ack_unused;
  assign irq_ack_unused = irq_ack;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mat_xpose_dma_ctrl.sv
module tb_mat_xpose_dma_ctrl;
  localparam int AW = 11;
  localparam int DW = 4;

  logic          mclk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] cfg_src, cfg_dst;
  logic [DW-1:0] cfg_rows, cfg_cols;
  logic          start, busy, done, irq, irq_ack;
  logic [AW-1:0] cpu_addr, mem_addr;
  logic          cpu_cen, mem_cen;
  logic [1:0]    cpu_wen, mem_wen;
  logic [15:0]   cpu_din, cpu_dout, mem_din, mem_dout;

  always #5 mclk = ~mclk;

  mat_xpose_dma_ctrl #(.ADDR_W(AW), .DIM_W(DW)) dut (
    .mclk(mclk), .reset_n(reset_n),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .start(start), .busy(busy), .done(done), .irq(irq), .irq_ack(irq_ack),
    .cpu_addr(cpu_addr), .cpu_cen(cpu_cen), .cpu_wen(cpu_wen), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout),
    .mem_addr(mem_addr), .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Behavioural single-port RAM; a preload image is copied in when fill_req is high.
  logic [15:0] ram      [0:2047];
  logic [15:0] fill_img [0:2047];
  logic [15:0] ram_dout = 16'h0;
  logic        fill_req = 1'b0;
  assign mem_dout = ram_dout;

  always @(posedge mclk) begin
    if (fill_req) begin
      for (int i = 0; i < 2048; i++) ram[i] <= fill_img[i];
    end else if (!mem_cen) begin
      ram_dout <= ram[mem_addr];
      if (!mem_wen[0]) ram[mem_addr][7:0]  <= mem_din[7:0];
      if (!mem_wen[1]) ram[mem_addr][15:8] <= mem_din[15:8];
    end
  end

  // Engine accesses: RAM enabled while the CPU is idle.
  int eng_cnt = 0;
  always @(posedge mclk) if (cpu_cen && !mem_cen) eng_cnt++;

  logic [15:0] shadow [0:255];   // CPU scratch area at 0x300..0x3FF
  int vec  = 0;
  int miss = 0;

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [DW-1:0] rows;
    logic [DW-1:0] cols;
    int            mode;     // 0 quiet, 1 random CPU, 2 5-cycle CPU burst in WR, 3 CPU in CAP, 4 restart attempt
    int            exp_lat;  // clocks from start to done, -1 = model only
  } vec_t;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit cpu_act(input int mode, input int p);
    case (mode)
      1:       return ($urandom_range(0, 2) == 0);
      2:       return (p >= 2 && p <= 6);
      3:       return (p == 1 || p == 4);
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_xfer(input vec_t v);
    int n, s, lat, mlat, busy_cnt, base, errs, k;
    bit act, fin, busy_seen;
    logic [15:0] srcw [0:224];
    logic [AW-1:0] a;
    n = int'(v.rows) * int'(v.cols);
    for (int i = 0; i < 2048; i++) fill_img[i] = 16'($urandom);
    for (int i = 0; i < 256; i++) fill_img[12'h300 + i] = shadow[i];
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    for (int i = 0; i < n; i++) srcw[i] = fill_img[AW'(v.src + AW'(i))];

    base = eng_cnt;
    cfg_src = v.src; cfg_dst = v.dst; cfg_rows = v.rows; cfg_cols = v.cols;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_src = AW'($urandom); cfg_dst = AW'($urandom);
    cfg_rows = DW'($urandom); cfg_cols = DW'($urandom);

    // Schedule model: 3 slots per element (read, capture, write); the read
    // and write slots only complete in a cycle where the CPU leaves the RAM.
    s = 0; lat = 1; mlat = 1; busy_cnt = 0; fin = (n == 0);
    if (n > 0) begin
      for (int p = 0; p < 5000; p++) begin
        act = cpu_act(v.mode, p);
        if (act) begin
          cpu_addr = AW'(12'h300 + $urandom_range(0, 255));
          k = int'($urandom_range(0, 2));
          cpu_wen = (k == 0) ? 2'b11 : (k == 1) ? 2'b00 : ($urandom_range(0, 1) != 0 ? 2'b01 : 2'b10);
          cpu_din = 16'($urandom);
          cpu_cen = 1'b0;
        end else begin
          cpu_cen = 1'b1;
          cpu_wen = 2'b11;
        end
        start = (v.mode == 4 && p == 3);
        #1;
        if (act) chk("arb", {2'b0, mem_cen, mem_wen, mem_addr, mem_din},
                            {2'b0, 1'b0, cpu_wen, cpu_addr, cpu_din});
        if (busy) busy_cnt++;
        if (!fin) begin
          if (!(act && (s % 3) != 1)) s++;
          if (s == 3 * n) begin
            fin  = 1'b1;
            mlat = lat + 1;
          end
        end
        tick();
        lat++;
        if (act) begin
          if (cpu_wen == 2'b11) chk("cpu_rd", 32'(cpu_dout), 32'(shadow[cpu_addr[7:0]]));
          else begin
            if (!cpu_wen[0]) shadow[cpu_addr[7:0]][7:0]  = cpu_din[7:0];
            if (!cpu_wen[1]) shadow[cpu_addr[7:0]][15:8] = cpu_din[15:8];
          end
        end
        if (done) break;
      end
    end
    cpu_cen = 1'b1; cpu_wen = 2'b11; start = 1'b0;

    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("latency_model", 32'(lat), 32'(mlat));
    if (v.exp_lat >= 0) chk("latency_table", 32'(lat), 32'(v.exp_lat));
    chk("busy_cycles", 32'(busy_cnt), 32'(mlat - 1));
`ifdef MAT_XPOSE_IRQ_EN
    chk("irq_with_done", 32'(irq), 32'd1);
`else
    chk("irq_tied_low", 32'(irq), 32'd0);
`endif
    tick();
    chk("done_pulse_end", 32'(done), 32'd0);
`ifdef MAT_XPOSE_IRQ_EN
    chk("irq_holds", 32'(irq), 32'd1);
`endif
    if (v.mode == 4) begin
      busy_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (busy) busy_seen = 1'b1;
      end
      chk("no_second_xfer", 32'(busy_seen), 32'd0);
    end
    chk("engine_accesses", 32'(eng_cnt - base), 32'(2 * n));
    errs = 0;
    for (int r = 0; r < int'(v.rows); r++)
      for (int c = 0; c < int'(v.cols); c++) begin
        a = AW'(v.dst + AW'(c * int'(v.rows) + r));
        if (ram[a] !== srcw[r * int'(v.cols) + c]) errs++;
      end
    chk("transpose", 32'(errs), 32'd0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("irq_after_ack", 32'(irq), 32'd0);
  endtask

  vec_t tbl [9];
  vec_t rv;
  int   base0;

  initial begin
    tbl[0] = '{src: 11'h100, dst: 11'h200, rows: 4'd3,  cols: 4'd4,  mode: 0, exp_lat: 37};
    tbl[1] = '{src: 11'h100, dst: 11'h200, rows: 4'd1,  cols: 4'd1,  mode: 0, exp_lat: 4};
    tbl[2] = '{src: 11'h100, dst: 11'h200, rows: 4'd0,  cols: 4'd5,  mode: 0, exp_lat: 1};
    tbl[3] = '{src: 11'h100, dst: 11'h200, rows: 4'd6,  cols: 4'd0,  mode: 0, exp_lat: 1};
    tbl[4] = '{src: 11'h080, dst: 11'h500, rows: 4'd2,  cols: 4'd5,  mode: 2, exp_lat: 36};
    tbl[5] = '{src: 11'h040, dst: 11'h480, rows: 4'd3,  cols: 4'd2,  mode: 3, exp_lat: 19};
    tbl[6] = '{src: 11'h100, dst: 11'h200, rows: 4'd2,  cols: 4'd3,  mode: 4, exp_lat: 19};
    tbl[7] = '{src: 11'h100, dst: 11'h7FA, rows: 4'd3,  cols: 4'd4,  mode: 0, exp_lat: 37};
    tbl[8] = '{src: 11'h000, dst: 11'h400, rows: 4'd15, cols: 4'd15, mode: 0, exp_lat: 676};

    reset_n = 1'b0; start = 1'b0; irq_ack = 1'b0;
    cfg_src = '0; cfg_dst = '0; cfg_rows = '0; cfg_cols = '0;
    cpu_addr = '0; cpu_cen = 1'b1; cpu_wen = 2'b11; cpu_din = '0;
    for (int i = 0; i < 256; i++) shadow[i] = 16'($urandom);
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_mem_cen", {29'b0, mem_cen, mem_wen}, 32'h7);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_xfer(tbl[i]);

    for (int i = 0; i < 6; i++) begin
      rv.src = AW'($urandom_range(0, 11'h1FF));
      rv.dst = AW'(11'h400 + $urandom_range(0, 11'h1FF));
      rv.rows = DW'($urandom_range(1, 15));
      rv.cols = DW'($urandom_range(1, 15));
      rv.mode = 1;
      rv.exp_lat = -1;
      run_xfer(rv);
    end

    // Reset in the middle of a transfer.
    cfg_src = 11'h100; cfg_dst = 11'h200; cfg_rows = 4'd4; cfg_cols = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("busy_before_abort", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_cen", 32'(mem_cen), 32'd1);
    base0 = eng_cnt;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chk("abort_no_access", 32'(eng_cnt - base0), 32'd0);
    chk("abort_busy_after", 32'(busy), 32'd0);
    chk("abort_done_after", 32'(done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
